rob_3way: RTL and testbench

- 3-wide reorder buffer sitting directly upstream of the retire stage.
- Allocates entries in program order from dispatch, and marks entries complete from up to 3 CDB broadcasts.
- Presents up to 3 oldest contiguous completed entries per cycle as ROB_RT_PACKET[2:0].
- Flushes completely when retire raises squash.

---
 rtl/sys_defs.sv | 30 +++
 rtl/rob_3way_if.sv | 21 ++
 rtl/rob_retire_select.sv | 27 ++
 rtl/rob_3way.sv | 152 +++++++++++++++
 tb/tb_rob_3way.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared ROB sizing plus the dispatch, CDB and retire packet formats.
package sys_defs;
  localparam int ROB_SZ    = 32;
  localparam int ROB_IDX_W = $clog2(ROB_SZ);
  localparam int N_WAY     = 3;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_reg_idx;
    logic [31:0] NPC;
    logic        halt;
  } DP_ROB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] tag;
    logic [31:0]          value;
    logic                 take_branch;
  } CDB_ROB_PACKET;

  typedef struct packed {
    logic [4:0]           dest_reg_idx;
    logic [31:0]          value;
    logic                 valid;
    logic                 take_branch;
    logic [31:0]          NPC;
    logic [ROB_IDX_W-1:0] tag;
    logic                 halt;
  } ROB_RT_PACKET;
endpackage

// File: rtl/rob_3way_if.sv
// Dispatch / CDB / retire bundle around the 3-wide reorder buffer.
interface rob_3way_if;
  import sys_defs::*;

  DP_ROB_PACKET  [2:0]                dp_rob_packet_in;
  CDB_ROB_PACKET [2:0]                cdb_rob_packet_in;
  logic                               squash_flag;
  logic          [2:0][ROB_IDX_W-1:0] rob_tag_out;
  logic          [1:0]                rob_free_slots;
  ROB_RT_PACKET  [2:0]                rob_rt_packet_out;

  modport master (
    output dp_rob_packet_in, cdb_rob_packet_in, squash_flag,
    input  rob_tag_out, rob_free_slots, rob_rt_packet_out
  );

  modport slave (
    input  dp_rob_packet_in, cdb_rob_packet_in, squash_flag,
    output rob_tag_out, rob_free_slots, rob_rt_packet_out
  );
endinterface

// File: rtl/rob_retire_select.sv
// Contiguous retire mask over the three oldest entries; the scan stops
// after the first taken branch or halt.
module rob_retire_select
  import sys_defs::*;
(
  input  logic [N_WAY-1:0] busy_i,
  input  logic [N_WAY-1:0] complete_i,
  input  logic [N_WAY-1:0] take_branch_i,
  input  logic [N_WAY-1:0] halt_i,
  output logic [N_WAY-1:0] mask_o,
  output logic [1:0]       cnt_o
);
  logic go;

  always_comb begin
    mask_o = '0;
    cnt_o  = '0;
    go     = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      go        = go & busy_i[i] & complete_i[i];
      mask_o[i] = go;
      cnt_o     = cnt_o + 2'(go);
      // the redirecting entry itself retires, nothing younger does
      go        = go & ~(take_branch_i[i] | halt_i[i]);
    end
  end
endmodule

// File: rtl/rob_3way.sv
// 3-wide reorder buffer: in-order allocate, out-of-order complete from the
// CDB, in-order retire of up to three contiguous completed entries.
module rob_3way
  import sys_defs::*;
(
  input  logic      clock,
  input  logic      reset_n,
  rob_3way_if.slave rob_if
);
  localparam logic [ROB_IDX_W:0] SZ_L  = (ROB_IDX_W+1)'(ROB_SZ);
  localparam logic [ROB_IDX_W:0] THREE = (ROB_IDX_W+1)'(3);

  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d, free_ent;
  logic [ROB_SZ-1:0]    busy_q, busy_d, cmpl_q, cmpl_d;
  logic [ROB_SZ-1:0]    br_q, halt_q;
  logic [4:0]           dest_q [ROB_SZ];
  logic [31:0]          val_q  [ROB_SZ];
  logic [31:0]          npc_q  [ROB_SZ];

  logic [1:0]                      free_slots, dp_n, rt_cnt;
  logic [N_WAY-1:0][ROB_IDX_W-1:0] dp_tag, rt_idx;
  logic [N_WAY-1:0]                dp_vld, dp_ok, cdb_ok, rt_mask;
  logic [N_WAY-1:0]                sel_busy, sel_cmpl, sel_br, sel_halt;
  logic                            cdb_dup;

  // Free count comes from registered occupancy only: a dispatch can never
  // land on an entry that is retiring in the same cycle.
  assign free_ent   = SZ_L - count_q;
  assign free_slots = (free_ent > THREE) ? 2'd3 : free_ent[1:0];

  always_comb begin
    dp_n = '0;
    for (int i = 0; i < N_WAY; i++) begin
      dp_tag[i]   = tail_q + ROB_IDX_W'(i);
      rt_idx[i]   = head_q + ROB_IDX_W'(i);
      dp_vld[i]   = rob_if.dp_rob_packet_in[i].valid;
      dp_ok[i]    = dp_vld[i] && (2'(i) < free_slots);
      dp_n        = dp_n + 2'(dp_ok[i]);
      sel_busy[i] = busy_q[rt_idx[i]];
      sel_cmpl[i] = cmpl_q[rt_idx[i]];
      sel_br[i]   = br_q[rt_idx[i]];
      sel_halt[i] = halt_q[rt_idx[i]];
    end
  end

  rob_retire_select u_sel (
    .busy_i        (sel_busy),
    .complete_i    (sel_cmpl),
    .take_branch_i (sel_br),
    .halt_i        (sel_halt),
    .mask_o        (rt_mask),
    .cnt_o         (rt_cnt)
  );

  assign rob_if.rob_tag_out    = dp_tag;
  assign rob_if.rob_free_slots = free_slots;

  always_comb begin
    rob_if.rob_rt_packet_out = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (rt_mask[i]) begin
        rob_if.rob_rt_packet_out[i].valid        = 1'b1;
        rob_if.rob_rt_packet_out[i].dest_reg_idx = dest_q[rt_idx[i]];
        rob_if.rob_rt_packet_out[i].value        = val_q[rt_idx[i]];
        rob_if.rob_rt_packet_out[i].take_branch  = br_q[rt_idx[i]];
        rob_if.rob_rt_packet_out[i].NPC          = npc_q[rt_idx[i]];
        rob_if.rob_rt_packet_out[i].tag          = rt_idx[i];
        rob_if.rob_rt_packet_out[i].halt         = halt_q[rt_idx[i]];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    cmpl_d = cmpl_q;
    cdb_ok = '0;
    for (int i = 0; i < N_WAY; i++)
      if (rt_mask[i]) begin
        busy_d[rt_idx[i]] = 1'b0;
        cmpl_d[rt_idx[i]] = 1'b0;
      end
    for (int i = 0; i < N_WAY; i++)
      if (dp_ok[i]) begin
        busy_d[dp_tag[i]] = 1'b1;
        cmpl_d[dp_tag[i]] = 1'b0;
      end
    // only entries that were live before this edge and are not leaving now
    for (int i = 0; i < N_WAY; i++) begin
      cdb_ok[i] = rob_if.cdb_rob_packet_in[i].valid
                  && busy_q[rob_if.cdb_rob_packet_in[i].tag]
                  && busy_d[rob_if.cdb_rob_packet_in[i].tag];
      if (cdb_ok[i]) cmpl_d[rob_if.cdb_rob_packet_in[i].tag] = 1'b1;
    end
    head_d  = head_q + ROB_IDX_W'(rt_cnt);
    tail_d  = tail_q + ROB_IDX_W'(dp_n);
    count_d = count_q + (ROB_IDX_W+1)'(dp_n) - (ROB_IDX_W+1)'(rt_cnt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      cmpl_q  <= '0;
    end else if (rob_if.squash_flag) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      cmpl_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      cmpl_q  <= cmpl_d;
    end
  end

  // Payload is qualified by busy/complete, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++)
      if (dp_ok[i]) begin
        dest_q[dp_tag[i]] <= rob_if.dp_rob_packet_in[i].dest_reg_idx;
        npc_q[dp_tag[i]]  <= rob_if.dp_rob_packet_in[i].NPC;
        halt_q[dp_tag[i]] <= rob_if.dp_rob_packet_in[i].halt;
        br_q[dp_tag[i]]   <= 1'b0;
      end
    for (int i = 0; i < N_WAY; i++)
      if (cdb_ok[i]) begin
        val_q[rob_if.cdb_rob_packet_in[i].tag] <= rob_if.cdb_rob_packet_in[i].value;
        br_q[rob_if.cdb_rob_packet_in[i].tag]  <= rob_if.cdb_rob_packet_in[i].take_branch;
      end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int i = 0; i < N_WAY; i++)
      for (int j = i + 1; j < N_WAY; j++)
        if (rob_if.cdb_rob_packet_in[i].valid && rob_if.cdb_rob_packet_in[j].valid
            && rob_if.cdb_rob_packet_in[i].tag == rob_if.cdb_rob_packet_in[j].tag)
          cdb_dup = 1'b1;
  end

  a_dp_fit: assert property (@(posedge clock) disable iff (!reset_n || rob_if.squash_flag)
    dp_vld == dp_ok);
  a_dp_contig: assert property (@(posedge clock) disable iff (!reset_n)
    dp_vld inside {3'b000, 3'b001, 3'b011, 3'b111});
  a_cdb_uniq: assert property (@(posedge clock) disable iff (!reset_n) !cdb_dup);
endmodule

// File: tb/tb_rob_3way.sv
// Random + directed bench for rob_3way against a queue-based ROB model.
module tb_rob_3way;
  import sys_defs::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  rob_3way_if bi();
  rob_3way dut (.clock(clock), .reset_n(reset_n), .rob_if(bi));
  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] npc;
    bit          halt;
    bit          done;
    logic [31:0] val;
    bit          tb;
  } ment_t;

  ment_t q[$];        // oldest first
  int    m_tail = 0;
  int    n_tot  = 0;
  int    n_bad  = 0;
  DP_ROB_PACKET  [2:0] dp_v;
  CDB_ROB_PACKET [2:0] cdb_v;
  logic                sq;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic int m_free();
    return (ROB_SZ - q.size() < 3) ? ROB_SZ - q.size() : 3;
  endfunction

  function automatic int m_rt_cnt();
    int n = 0;
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      if (!q[i].done) break;
      n++;
      if (q[i].tb || q[i].halt) break;
    end
    return n;
  endfunction

  task automatic check_all();
    int n;
    ROB_RT_PACKET e;
    n = m_rt_cnt();
    chk("free", 128'(bi.rob_free_slots), 128'(m_free()));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tag%0d", i), 128'(bi.rob_tag_out[i]), 128'((m_tail + i) % ROB_SZ));
      e = '0;
      if (i < n) begin
        e.valid        = 1'b1;
        e.dest_reg_idx = q[i].dest;
        e.value        = q[i].val;
        e.take_branch  = q[i].tb;
        e.NPC          = q[i].npc;
        e.tag          = ROB_IDX_W'(q[i].tag);
        e.halt         = q[i].halt;
      end
      chk($sformatf("rt%0d", i), 128'(bi.rob_rt_packet_out[i]), 128'(e));
    end
  endtask

  task automatic model_update();
    int n, f;
    ment_t m;
    if (sq) begin
      q.delete();
      m_tail = 0;
      return;
    end
    f = m_free();
    n = m_rt_cnt();
    repeat (n) void'(q.pop_front());
    for (int s = 0; s < 3; s++)
      if (cdb_v[s].valid)
        foreach (q[k])
          if (q[k].tag == int'(cdb_v[s].tag)) begin
            q[k].done = 1'b1;
            q[k].val  = cdb_v[s].value;
            q[k].tb   = cdb_v[s].take_branch;
          end
    for (int s = 0; s < 3; s++)
      if (dp_v[s].valid && s < f) begin
        m = '{m_tail, dp_v[s].dest_reg_idx, dp_v[s].NPC, dp_v[s].halt, 1'b0, 32'h0, 1'b0};
        q.push_back(m);
        m_tail = (m_tail + 1) % ROB_SZ;
      end
  endtask

  task automatic step();
    bi.dp_rob_packet_in  = dp_v;
    bi.cdb_rob_packet_in = cdb_v;
    bi.squash_flag       = sq;
    model_update();
    @(posedge clock);
    @(negedge clock);
    dp_v = '0;
    cdb_v = '0;
    sq = 1'b0;
    bi.dp_rob_packet_in  = '0;
    bi.cdb_rob_packet_in = '0;
    bi.squash_flag       = 1'b0;
    check_all();
  endtask

  task automatic dp_set(input int n, input int dest0, input bit h0);
    for (int i = 0; i < n; i++) begin
      dp_v[i].valid        = 1'b1;
      dp_v[i].dest_reg_idx = 5'(dest0 + i);
      dp_v[i].NPC          = $urandom;
      dp_v[i].halt         = (i == 0) && h0;
    end
  endtask

  task automatic cdb_set(input int s, input int tag, input logic [31:0] v, input bit tb);
    cdb_v[s].valid       = 1'b1;
    cdb_v[s].tag         = ROB_IDX_W'(tag);
    cdb_v[s].value       = v;
    cdb_v[s].take_branch = tb;
  endtask

  task automatic complete_some(input int k);
    int s = 0;
    foreach (q[i])
      if (!q[i].done && s < k) begin
        cdb_set(s, q[i].tag, $urandom, 1'b0);
        s++;
      end
  endtask

  task automatic drain();
    for (int it = 0; it < 60 && q.size() > 0; it++) begin
      complete_some(3);
      step();
    end
  endtask

  task automatic rand_phase();
    int f, nd, j;
    int pool[$];
    bit nb_used;
    for (int cyc = 0; cyc < 400; cyc++) begin
      f  = m_free();
      nd = int'($urandom_range(32'(f), 0));
      if (nd > 0) dp_set(nd, int'($urandom_range(31, 0)), ($urandom_range(15, 0) == 0));
      pool.delete();
      foreach (q[k]) if (!q[k].done) pool.push_back(q[k].tag);
      nb_used = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(1, 0) == 1 && pool.size() > 0) begin
          j = int'($urandom_range(32'(pool.size() - 1), 0));
          cdb_set(s, pool[j], $urandom, ($urandom_range(3, 0) == 0));
          pool.delete(j);
        end else if (!nb_used && q.size() < ROB_SZ && $urandom_range(7, 0) == 0) begin
          // a broadcast to a free entry must be dropped
          cdb_set(s, (m_tail + int'($urandom_range(32'(ROB_SZ - 1 - q.size()), 0))) % ROB_SZ,
                  $urandom, 1'b1);
          nb_used = 1'b1;
        end
      end
      sq = ($urandom_range(63, 0) == 0);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1);
  end

  initial begin
    int b;
    dp_v = '0; cdb_v = '0; sq = 1'b0;
    bi.dp_rob_packet_in = '0; bi.cdb_rob_packet_in = '0; bi.squash_flag = 1'b0;
    repeat (2) @(negedge clock);
    check_all();
    chk("rst_free", 128'(bi.rob_free_slots), 128'(2'd3));
    chk("rst_tag2", 128'(bi.rob_tag_out[2]), 128'(5'd2));
    reset_n = 1'b1;
    step();

    // in-order retire after out-of-order completion
    dp_set(3, 5, 1'b0); step();
    cdb_set(0, 1, 32'h11, 1'b0); step();
    chk("t2_none", 128'(bi.rob_rt_packet_out[0].valid), 128'(1'b0));
    cdb_set(0, 0, 32'h10, 1'b0); step();
    chk("t2_rt0_v",  128'(bi.rob_rt_packet_out[0].valid), 128'(1'b1));
    chk("t2_rt0_d",  128'(bi.rob_rt_packet_out[0].dest_reg_idx), 128'(5'd5));
    chk("t2_rt0_x",  128'(bi.rob_rt_packet_out[0].value), 128'(32'h10));
    chk("t2_rt1_d",  128'(bi.rob_rt_packet_out[1].dest_reg_idx), 128'(5'd6));
    chk("t2_rt1_x",  128'(bi.rob_rt_packet_out[1].value), 128'(32'h11));
    chk("t2_rt2_v",  128'(bi.rob_rt_packet_out[2].valid), 128'(1'b0));
    complete_some(3); step();
    step();

    // taken branch ends the retire group
    b = m_tail;
    dp_set(3, 8, 1'b0); step();
    cdb_set(0, b, 32'h1, 1'b0);
    cdb_set(1, (b + 1) % ROB_SZ, 32'h400, 1'b1);
    cdb_set(2, (b + 2) % ROB_SZ, 32'h3, 1'b0);
    step();
    chk("t3_rt0_v", 128'(bi.rob_rt_packet_out[0].valid), 128'(1'b1));
    chk("t3_rt1_v", 128'(bi.rob_rt_packet_out[1].valid), 128'(1'b1));
    chk("t3_rt1_x", 128'(bi.rob_rt_packet_out[1].value), 128'(32'h400));
    chk("t3_rt2_v", 128'(bi.rob_rt_packet_out[2].valid), 128'(1'b0));
    step();
    chk("t3_head", 128'(bi.rob_rt_packet_out[0].tag), 128'(ROB_IDX_W'(b + 2)));
    step();

    // halt ends the retire group
    b = m_tail;
    dp_set(3, 12, 1'b1); step();
    complete_some(3); step();
    chk("t4_rt0_h", 128'(bi.rob_rt_packet_out[0].halt), 128'(1'b1));
    chk("t4_rt1_v", 128'(bi.rob_rt_packet_out[1].valid), 128'(1'b0));
    step();
    chk("t4_head", 128'(bi.rob_rt_packet_out[0].tag), 128'(ROB_IDX_W'(b + 1)));
    step();

    // fill, free three, wrap the tail
    sq = 1'b1; step();
    for (int it = 0; it < 20 && m_free() > 0; it++) begin
      dp_set(m_free(), it, 1'b0);
      step();
    end
    chk("t5_full", 128'(bi.rob_free_slots), 128'(2'd0));
    for (int s = 0; s < 3; s++) cdb_set(s, s, 32'(s + 100), 1'b0);
    step();
    chk("t5_still_full", 128'(bi.rob_free_slots), 128'(2'd0));
    step();
    chk("t5_free3", 128'(bi.rob_free_slots), 128'(2'd3));
    chk("t5_wrap0", 128'(bi.rob_tag_out[0]), 128'(ROB_IDX_W'(0)));
    chk("t5_wrap2", 128'(bi.rob_tag_out[2]), 128'(ROB_IDX_W'(2)));
    dp_set(3, 20, 1'b0); step();
    drain();

    // squash beats same-cycle dispatch and CDB
    dp_set(3, 1, 1'b0); step();
    dp_set(2, 9, 1'b0);
    cdb_set(0, q[0].tag, 32'h55, 1'b0);
    sq = 1'b1;
    step();
    chk("t6_free", 128'(bi.rob_free_slots), 128'(2'd3));
    chk("t6_tag0", 128'(bi.rob_tag_out[0]), 128'(ROB_IDX_W'(0)));
    chk("t6_rt0_v", 128'(bi.rob_rt_packet_out[0].valid), 128'(1'b0));

    // asynchronous reset mid-stream
    dp_set(3, 2, 1'b0); step();
    complete_some(3); step();
    chk("t7_pre", 128'(bi.rob_rt_packet_out[0].valid), 128'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_tail = 0;
    check_all();
    chk("t7_free", 128'(bi.rob_free_slots), 128'(2'd3));
    @(negedge clock);
    reset_n = 1'b1;
    step();

    rand_phase();
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
